// File: rtl/tile_video_pkg.sv
// Shared command encoding and map-entry layout for the tile video memory.
// Imported by the top level and by the bench.
package tile_video_pkg;

  typedef enum logic [1:0] {
    TGT_PATTERN = 2'b00,
    TGT_MAP     = 2'b01,
    TGT_PALETTE = 2'b10,
    TGT_CTRL    = 2'b11
  } target_e;

  typedef struct packed {
    target_e     target;
    logic [13:0] addr;
    logic [15:0] data;
  } cmd_t;

  localparam logic [13:0] CTRL_SCROLL_X   = 14'd0;
  localparam logic [13:0] CTRL_SCROLL_Y   = 14'd1;
  localparam logic [13:0] CTRL_BACKGROUND = 14'd2;

  localparam int MAP_PAL_LSB   = 12;
  localparam int MAP_HFLIP_BIT = 14;
  localparam int MAP_VFLIP_BIT = 15;

  localparam int RGB565_W = 16;

endpackage

// File: rtl/tile_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module tile_sdp_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tile_video_memory.sv
// Tile-map / pattern video memory: command writes into pattern, map and
// palette RAMs plus control registers, and a 4-stage pixel lookup to RGB565.
module tile_video_memory
  import tile_video_pkg::*;
#(
  parameter int DISPLAY_WIDTH        = 240,
  parameter int DISPLAY_HEIGHT       = 320,
  parameter int TILE_SIZE            = 8,
  parameter int BPP                  = 2,
  parameter int TILE_COUNT           = 256,
  parameter int MAP_TILES_X          = 32,
  parameter int MAP_TILES_Y          = 64,
  parameter int PALETTE_COUNT        = 4,
  parameter int WRITE_DURING_DISPLAY = 0,
  localparam int X_BITS = $clog2(DISPLAY_WIDTH),
  localparam int Y_BITS = $clog2(DISPLAY_HEIGHT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  input  logic [31:0]         cmd_data,
  output logic                cmd_ready,
  input  logic                in_display_region,
  input  logic                frame_start,
  input  logic                pix_req,
  input  logic [X_BITS-1:0]   pix_x,
  input  logic [Y_BITS-1:0]   pix_y,
  output logic                pix_valid,
  output logic [RGB565_W-1:0] pix_data
);

  localparam int WPR       = TILE_SIZE * BPP / 16;
  localparam int TILE_BITS = $clog2(TILE_COUNT);
  localparam int PAL_BITS  = (PALETTE_COUNT > 1) ? $clog2(PALETTE_COUNT) : 1;
  localparam int TS_BITS   = $clog2(TILE_SIZE);
  localparam int MX_BITS   = $clog2(MAP_TILES_X) + TS_BITS;
  localparam int MY_BITS   = $clog2(MAP_TILES_Y) + TS_BITS;
  localparam int CB_W      = TS_BITS + 3;

  localparam int PAT_DEPTH = TILE_COUNT * TILE_SIZE * WPR;
  localparam int MAP_DEPTH = MAP_TILES_X * MAP_TILES_Y;
  localparam int PAL_DEPTH = PALETTE_COUNT * (2 ** BPP);
  localparam int PAT_AW    = $clog2(PAT_DEPTH);
  localparam int MAP_AW    = $clog2(MAP_DEPTH);
  localparam int PAL_AW    = $clog2(PAL_DEPTH);

  cmd_t        cmd;
  logic        accept;
  logic [31:0] addr_ext;
  logic        pat_we, map_we, pal_we, ctrl_we;

  assign cmd       = cmd_data;
  assign cmd_ready = reset && ((WRITE_DURING_DISPLAY != 0) || !in_display_region);
  assign accept    = cmd_valid && cmd_ready;
  assign addr_ext  = {18'd0, cmd.addr};

  // Out-of-range addresses are still consumed; only the write enable drops.
  assign pat_we  = accept && (cmd.target == TGT_PATTERN) && (addr_ext < PAT_DEPTH);
  assign map_we  = accept && (cmd.target == TGT_MAP)     && (addr_ext < MAP_DEPTH);
  assign pal_we  = accept && (cmd.target == TGT_PALETTE) && (addr_ext < PAL_DEPTH);
  assign ctrl_we = accept && (cmd.target == TGT_CTRL);

  logic [MX_BITS-1:0]  scroll_x_shadow_reg, scroll_x_shadow_next, scroll_x_live_reg;
  logic [MY_BITS-1:0]  scroll_y_shadow_reg, scroll_y_shadow_next, scroll_y_live_reg;
  logic [RGB565_W-1:0] background_reg;

  always_comb begin
    scroll_x_shadow_next = scroll_x_shadow_reg;
    scroll_y_shadow_next = scroll_y_shadow_reg;
    if (ctrl_we && cmd.addr == CTRL_SCROLL_X) scroll_x_shadow_next = cmd.data[MX_BITS-1:0];
    if (ctrl_we && cmd.addr == CTRL_SCROLL_Y) scroll_y_shadow_next = cmd.data[MY_BITS-1:0];
  end

  // Live scroll picks up a shadow write landing in the frame_start cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scroll_x_shadow_reg <= '0;
      scroll_y_shadow_reg <= '0;
      scroll_x_live_reg   <= '0;
      scroll_y_live_reg   <= '0;
      background_reg      <= '0;
    end else begin
      scroll_x_shadow_reg <= scroll_x_shadow_next;
      scroll_y_shadow_reg <= scroll_y_shadow_next;
      if (frame_start) begin
        scroll_x_live_reg <= scroll_x_shadow_next;
        scroll_y_live_reg <= scroll_y_shadow_next;
      end
      if (ctrl_we && cmd.addr == CTRL_BACKGROUND) background_reg <= cmd.data;
    end
  end

  logic [MAP_AW-1:0] map_raddr;
  logic [PAT_AW-1:0] pat_raddr;
  logic [PAL_AW-1:0] pal_raddr;
  logic [15:0]       map_rdata, pat_rdata;
  logic [RGB565_W-1:0] pal_rdata;

  tile_sdp_ram #(.DEPTH(PAT_DEPTH), .WIDTH(16)) u_pattern_ram (
    .clk(clk), .we(pat_we), .waddr(cmd.addr[PAT_AW-1:0]), .wdata(cmd.data),
    .raddr(pat_raddr), .rdata(pat_rdata)
  );

  tile_sdp_ram #(.DEPTH(MAP_DEPTH), .WIDTH(16)) u_map_ram (
    .clk(clk), .we(map_we), .waddr(cmd.addr[MAP_AW-1:0]), .wdata(cmd.data),
    .raddr(map_raddr), .rdata(map_rdata)
  );

  tile_sdp_ram #(.DEPTH(PAL_DEPTH), .WIDTH(RGB565_W)) u_palette_ram (
    .clk(clk), .we(pal_we), .waddr(cmd.addr[PAL_AW-1:0]), .wdata(cmd.data),
    .raddr(pal_raddr), .rdata(pal_rdata)
  );

  logic               s1_valid, s2_valid, s3_valid, s4_valid;
  logic [MX_BITS-1:0] s1_mx;
  logic [MY_BITS-1:0] s1_my;
  logic [TS_BITS-1:0] s2_col, s2_row;
  logic [3:0]         s3_bit_off;
  logic [PAL_BITS-1:0] s3_pal;
  logic [BPP-1:0]     s4_idx;

  logic [MX_BITS-1:0]  mx_next;
  logic [MY_BITS-1:0]  my_next;
  logic [TILE_BITS-1:0] map_tile;
  logic [PAL_BITS-1:0] map_pal;
  logic [TS_BITS-1:0]  tile_col, tile_row;
  logic [CB_W-1:0]     col_bits;
  logic [BPP-1:0]      pat_idx;
  logic                unused_map_bits;

  // Map dimensions are powers of two, so the wrap is a plain truncation.
  assign mx_next   = MX_BITS'(pix_x) + scroll_x_live_reg;
  assign my_next   = MY_BITS'(pix_y) + scroll_y_live_reg;
  assign map_raddr = {s1_my[MY_BITS-1:TS_BITS], s1_mx[MX_BITS-1:TS_BITS]};

  assign map_tile  = map_rdata[TILE_BITS-1:0];
  assign map_pal   = map_rdata[MAP_PAL_LSB +: PAL_BITS] & PAL_BITS'(PALETTE_COUNT - 1);
  assign tile_col  = map_rdata[MAP_HFLIP_BIT] ? ~s2_col : s2_col;
  assign tile_row  = map_rdata[MAP_VFLIP_BIT] ? ~s2_row : s2_row;
  assign col_bits  = CB_W'(tile_col) * CB_W'(BPP);
  assign pat_raddr = PAT_AW'(map_tile) * PAT_AW'(TILE_SIZE * WPR)
                   + PAT_AW'(tile_row) * PAT_AW'(WPR)
                   + PAT_AW'(col_bits >> 4);
  assign unused_map_bits = ^map_rdata;

  assign pat_idx   = pat_rdata[s3_bit_off +: BPP];
  assign pal_raddr = PAL_AW'(s3_pal) * PAL_AW'(2 ** BPP) + PAL_AW'(pat_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s3_valid   <= 1'b0;
      s4_valid   <= 1'b0;
      s1_mx      <= '0;
      s1_my      <= '0;
      s2_col     <= '0;
      s2_row     <= '0;
      s3_bit_off <= '0;
      s3_pal     <= '0;
      s4_idx     <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
    end else begin
      s1_valid   <= pix_req;
      s1_mx      <= mx_next;
      s1_my      <= my_next;
      s2_valid   <= s1_valid;
      s2_col     <= s1_mx[TS_BITS-1:0];
      s2_row     <= s1_my[TS_BITS-1:0];
      s3_valid   <= s2_valid;
      s3_bit_off <= col_bits[3:0];
      s3_pal     <= map_pal;
      s4_valid   <= s3_valid;
      s4_idx     <= pat_idx;
      pix_valid  <= s4_valid;
      if (s4_valid) pix_data <= (s4_idx == '0) ? background_reg : pal_rdata;
    end
  end

endmodule
